// File: rtl/riscv_pipe_elastic.sv
// riscv_pipe_elastic
// ------------------
// An elastic pipeline register made of DEPTH valid-tagged stages. It sits
// between two core pipeline stages and uses valid/ready handshakes on both
// sides. Empty stages (bubbles) collapse, so an item always advances when
// there is room anywhere downstream of it. A global flush clears every stage.
// A per-stage kill squashes individual speculative items.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset
//   flush_i        clear every stage at the next edge, blocks both handshakes
//   kill_i         per-stage squash, bit k drops the item held in stage k
//   in_valid_i     upstream item present
//   in_ready_o     stage 0 can accept this cycle
//   in_data_i      upstream payload
//   out_valid_o    item available at stage DEPTH-1
//   out_ready_i    downstream accepts
//   out_data_o     payload held in stage DEPTH-1
//   stage_valid_o  registered valid bit of every stage
//   count_o        number of occupied stages, registered

module riscv_pipe_elastic #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      DEPTH      = 3,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [DEPTH-1:0]           kill_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_data_o,
    output logic [DEPTH-1:0]           stage_valid_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CW-1:0]    r_count;

    logic [DEPTH-1:0] w_ev;
    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_downRdy;
    logic [DEPTH-1:0] w_srcValid;
    logic [WIDTH-1:0] w_srcData [DEPTH];
    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_clear;
    logic [DEPTH-1:0] w_vNext;
    logic [CW-1:0]    w_countNext;

    // A killed item behaves as if its stage were already empty.
    assign w_ev = r_v & ~kill_i;

    // Stage k is ready when some stage at or downstream of k is empty, or when
    // the consumer takes the output. The ripple is unrolled into a running AND
    // of effective valids, so no signal depends on itself.
    always_comb begin : readyChain
        logic allFull;
        allFull = 1'b1;
        w_rdy   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            allFull  = allFull & w_ev[k];
            w_rdy[k] = ~allFull | out_ready_i;
        end
    end

    // The readiness seen by each stage's item: the next stage's ready, or the
    // consumer's ready for the last stage.
    always_comb begin
        w_downRdy            = '0;
        w_downRdy[DEPTH-1]   = out_ready_i;
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_downRdy[k] = w_rdy[k+1];
        end
    end

    // Each stage is fed by the stage just upstream of it. Stage 0 is fed by
    // the input port.
    always_comb begin
        w_srcValid    = '0;
        w_srcValid[0] = in_valid_i;
        w_srcData[0]  = in_data_i;
        for (int k = 1; k < DEPTH; k++) begin
            w_srcValid[k] = w_ev[k-1];
            w_srcData[k]  = r_d[k-1];
        end
    end

    // A load has priority over clearing. A stage is cleared when its item
    // leaves without being replaced, or when it is killed and nothing refills it.
    // Clearing an already-empty stage is harmless because its data is
    // RESET_DATA anyway.
    always_comb begin
        w_load      = w_srcValid & w_rdy;
        w_clear     = ~w_load & ((w_ev & w_downRdy) | kill_i);
        w_vNext     = (r_v | w_load) & ~w_clear;
        w_countNext = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_countNext = w_countNext + CW'(w_vNext[k]);
        end
    end

    // Stage registers. Reset and flush both empty the whole pipe. Otherwise
    // each stage loads, clears or holds, and the occupancy count follows the
    // new valid vector.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_v     <= '0;
            r_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_d[k] <= RESET_DATA;
            end
        end else begin
            r_v     <= w_vNext;
            r_count <= w_countNext;
            for (int k = 0; k < DEPTH; k++) begin
                if (w_load[k]) begin
                    r_d[k] <= w_srcData[k];
                end else if (w_clear[k]) begin
                    r_d[k] <= RESET_DATA;
                end
            end
        end
    end

    assign in_ready_o    = w_rdy[0] & ~flush_i;
    assign out_valid_o   = w_ev[DEPTH-1] & ~flush_i;
    assign out_data_o    = r_d[DEPTH-1];
    assign stage_valid_o = r_v;
    assign count_o       = r_count;

endmodule

// File: tb/tb_riscv_pipe_elastic.sv
// tb_riscv_pipe_elastic
// ---------------------
// Bench for riscv_pipe_elastic with WIDTH=32 and DEPTH=3. A slot-level model
// of the pipe checks every DUT output in every cycle. Directed scenarios pin
// the model with hand-computed expectations, and a randomized phase follows.

`timescale 1ns/1ps

module tb_riscv_pipe_elastic;

    localparam int unsigned   WIDTH      = 32;
    localparam int unsigned   DEPTH      = 3;
    localparam logic [31:0]   RESET_DATA = 32'h0;
    localparam int unsigned   CW         = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [DEPTH-1:0]  kill;
    logic              inValid;
    logic              inReady;
    logic [WIDTH-1:0]  inData;
    logic              outValid;
    logic              outReady;
    logic [WIDTH-1:0]  outData;
    logic [DEPTH-1:0]  stageValid;
    logic [CW-1:0]     count;

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] outQ [$];

    // Model state: one slot per stage, holding an occupied flag and a payload.
    bit               mV [DEPTH];
    logic [WIDTH-1:0] mD [DEPTH];
    bit               modelKnown = 1'b0;

    always #5 clk = ~clk;

    riscv_pipe_elastic #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .RESET_DATA(RESET_DATA)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .kill_i(kill),
        .in_valid_i(inValid),
        .in_ready_o(inReady),
        .in_data_i(inData),
        .out_valid_o(outValid),
        .out_ready_i(outReady),
        .out_data_o(outData),
        .stage_valid_o(stageValid),
        .count_o(count)
    );

    // Every comparison goes through here so that both counters stay honest.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge.
    task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d, input bit ordy,
                                 input logic [DEPTH-1:0] k, input bit fl, input bit r);
        @(posedge clk);
        #1;
        inValid  = v;
        inData   = d;
        outReady = ordy;
        kill     = k;
        flush    = fl;
        rst      = r;
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, ordy, '0, 1'b0, 1'b0);
    endtask

    // Length of the run of live items packed against the output end that
    // cannot move this cycle. With out_ready high nothing is stuck.
    function automatic int tailRun();
        int n;
        bit going;
        n     = 0;
        going = 1'b1;
        if (outReady) return 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (going && mV[k] && !kill[k]) n++;
            else going = 1'b0;
        end
        return n;
    endfunction

    task automatic modelClear();
        for (int k = 0; k < DEPTH; k++) begin
            mV[k] = 1'b0;
            mD[k] = RESET_DATA;
        end
    endtask

    // Advance the model by one edge. Killed items vanish, the stuck tail
    // stays put, every other live item moves one slot toward the output (the
    // last one leaves), and a new item enters slot 0 when the pipe is not
    // completely stuck.
    task automatic modelStep();
        bit               nV [DEPTH];
        logic [WIDTH-1:0] nD [DEPTH];
        int               stuck;
        stuck = tailRun();
        for (int k = 0; k < DEPTH; k++) begin
            nV[k] = 1'b0;
            nD[k] = RESET_DATA;
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (mV[k] && !kill[k]) begin
                if (k >= DEPTH - stuck) begin
                    nV[k] = 1'b1;
                    nD[k] = mD[k];
                end else if (k < DEPTH - 1) begin
                    nV[k+1] = 1'b1;
                    nD[k+1] = mD[k];
                end
            end
        end
        if (inValid && stuck < DEPTH) begin
            nV[0] = 1'b1;
            nD[0] = inData;
        end
        for (int k = 0; k < DEPTH; k++) begin
            mV[k] = nV[k];
            mD[k] = nD[k];
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            modelClear();
            modelKnown = 1'b1;
        end else if (modelKnown) begin
            if (flush) modelClear();
            else modelStep();
        end
    end

    // Compare process: mid-cycle, check every output against the model.
    always @(negedge clk) begin
        if (modelKnown) begin
            logic [DEPTH-1:0] expStage;
            int               expCount;
            expCount = 0;
            for (int k = 0; k < DEPTH; k++) begin
                expStage[k] = mV[k];
                expCount   += int'(mV[k]);
            end
            checkOutput("model in_ready", inReady, !flush && (tailRun() < DEPTH));
            checkOutput("model out_valid", outValid, !flush && mV[DEPTH-1] && !kill[DEPTH-1]);
            checkOutput("model out_data", outData, mD[DEPTH-1]);
            checkOutput("model stage_valid", stageValid, expStage);
            checkOutput("model count", count, expCount);
        end
    end

    // Record every completed output transfer.
    always @(negedge clk) begin
        if (outValid && outReady && !rst) outQ.push_back(outData);
    end

    function automatic logic [WIDTH-1:0] qAt(input int i);
        if (i < outQ.size()) return outQ[i];
        return 'x;
    endfunction

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;
        rst = 1'b1; flush = 1'b0; kill = '0; inValid = 1'b0; inData = '0; outReady = 1'b0;

        // Reset, then a single item through an empty pipe.
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset in_ready", inReady, 1);
        checkOutput("reset out_valid", outValid, 0);
        checkOutput("reset out_data", outData, RESET_DATA);
        checkOutput("reset stage_valid", stageValid, 0);
        checkOutput("reset count", count, 0);
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, '0, 1'b0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("latency out_valid", outValid, c == 3);
            if (c == 3) checkOutput("latency out_data", outData, 32'hDEADBEEF);
        end
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("latency count drained", count, 0);
        checkOutput("latency out_valid drained", outValid, 0);

        // Back-to-back stream with the consumer always ready.
        outQ.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, WIDTH'(i), 1'b1, '0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("stream in_ready", inReady, 1);
        end
        idle(1'b1, 5);
        checkOutput("stream count", outQ.size(), 10);
        for (int i = 0; i < 10; i++) checkOutput("stream order", qAt(i), i);

        // Back-pressure: four items offered, three fit.
        outQ.delete();
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, WIDTH'(100 + idx), 1'b0, '0, 1'b0, 1'b0);
            @(negedge clk);
            if (inReady) idx++;
        end
        checkOutput("full accepted", idx, 3);
        checkOutput("full count", count, 3);
        checkOutput("full in_ready", inReady, 0);
        applyStimulus(1'b1, WIDTH'(100 + idx), 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("release in_ready", inReady, 1);
        idle(1'b1, 5);
        checkOutput("release count", outQ.size(), 4);
        for (int i = 0; i < 4; i++) checkOutput("release order", qAt(i), 100 + i);

        // Kill the middle stage of A,B,C.
        outQ.delete();
        applyStimulus(1'b1, 32'hA, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("kill before stage_valid", stageValid, 3'b111);
        checkOutput("kill before out_data", outData, 32'hA);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("kill after stage_valid", stageValid, 3'b110);
        checkOutput("kill after count", count, 2);
        idle(1'b1, 4);
        checkOutput("kill out count", outQ.size(), 2);
        checkOutput("kill out first", qAt(0), 32'hA);
        checkOutput("kill out second", qAt(1), 32'hC);

        // Flush a full pipe while both sides try to transfer.
        applyStimulus(1'b1, 32'hD, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hE, 1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hF, 1'b0, '0, 1'b0, 1'b0);
        outQ.delete();
        applyStimulus(1'b1, 32'h55, 1'b1, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("flush in_ready", inReady, 0);
        checkOutput("flush out_valid", outValid, 0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush stage_valid", stageValid, 0);
        checkOutput("flush out_data", outData, RESET_DATA);
        checkOutput("flush count", count, 0);
        checkOutput("flush no output", outQ.size(), 0);

        // Reset with two items in flight.
        applyStimulus(1'b1, 32'h111, 1'b1, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h222, 1'b1, '0, 1'b0, 1'b0);
        outQ.delete();
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h333, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midreset count", count, 0);
        checkOutput("midreset stage_valid", stageValid, 0);
        checkOutput("midreset in_ready", inReady, 1);
        checkOutput("midreset out_valid", outValid, 0);
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("midreset latency", outValid, c == 3);
            if (c == 3) checkOutput("midreset data", outData, 32'h333);
        end
        idle(1'b1, 3);
        checkOutput("midreset out count", outQ.size(), 1);
        checkOutput("midreset out item", qAt(0), 32'h333);

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom),
                          ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 7) == 0) ? DEPTH'($urandom_range(0, 7)) : '0,
                          ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 199) == 0));
        end
        idle(1'b1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_pipe_elastic.md
# riscv_pipe_elastic

Parametrised elastic pipeline register. It replaces single-stage stall/flush registers between core pipeline stages with a DEPTH-deep chain of valid-tagged stages. Flow control is valid/ready, and bubbles collapse so that empty stages never block traffic. It supports a global flush and a per-stage kill for squashing speculative instructions.

## Interface
- WIDTH, 32, payload width in bits (>=1)
- DEPTH, 3, number of register stages (1..8)
- RESET_DATA, 0, value loaded into data registers on reset, flush and kill
- clk_i  input  1  clock; all state updates on `CLOCK_EDGE
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  clear every stage
- kill_i  input  DEPTH  per-stage squash; bit k squashes stage k
- in_valid_i  input  1  upstream item present
- in_ready_o  output  1  stage 0 can accept this cycle
- in_data_i  input  WIDTH  upstream payload
- out_valid_o  output  1  item available at stage DEPTH-1
- out_ready_i  input  1  downstream accepts
- out_data_o  output  WIDTH  payload of stage DEPTH-1
- stage_valid_o  output  DEPTH  registered valid bit per stage
- count_o  output  $clog2(DEPTH+1)  number of registered valid stages

## Operation
- State per stage k (0 = input side, DEPTH-1 = output side): v[k] and d[k].
- Effective valid: ev[k] = v[k] & ~kill_i[k], combinational. A killed item is dropped at the next edge. It never transfers and is never presented.
- Ready chain:
  - rdy[DEPTH-1] = ~ev[DEPTH-1] | out_ready_i
  - rdy[k] = ~ev[k] | rdy[k+1]
  - This gives bubble collapse: any empty stage lets everything upstream of it advance.
- Outputs:
  - in_ready_o = rdy[0] & ~flush_i
  - out_valid_o = ev[DEPTH-1] & ~flush_i
  - out_data_o = d[DEPTH-1]
- Transfers:
  - In: in_valid_i & in_ready_o.
  - Out: out_valid_o & out_ready_i.
  - Stage k to k+1: ev[k] & rdy[k+1].
- Stage update, in priority order:
  - rst_i: v = 0, d = RESET_DATA.
  - flush_i: v = 0, d = RESET_DATA. Any input or output in the same cycle is not a transfer.
  - Load: stage k loads from stage k-1, or from the input for k = 0, when the source ev is set and rdy[k] is high. It sets v[k] = 1 and copies the data.
  - Vacate: stage k is vacated when it hands off (or outputs) without a reload. It then sets v[k] = 0 and d[k] = RESET_DATA.
  - Kill without reload: v[k] = 0, d[k] = RESET_DATA.
  - Otherwise: hold.
- The data register changes only on load, vacate, kill, flush or reset.
- count_o = popcount(v), registered, so it reflects state after the last edge.
- in_ready_o depends combinationally on out_ready_i and kill_i. Upstream must not make in_valid_i depend on in_ready_o.
- Valid-hold rule: an item with out_valid_o high and out_ready_i low stays, with out_data_o stable, until it is accepted, killed or flushed.

## Timing
- After reset, all outputs read 0 except the following:
  - in_ready_o = 1 (when flush_i is low)
  - out_data_o = RESET_DATA
- Latency into an empty pipe: an item accepted at edge t is at stage DEPTH-1 after edge t+DEPTH-1. out_valid_o is high in the cycle that follows, which gives DEPTH cycles from in_valid_i to out_valid_o.
- Throughput: 1 item per cycle while out_ready_i is held high.
- Full (all v set, out_ready_i low): in_ready_o = 0. Raising out_ready_i restores in_ready_o in the same cycle, with no bubble.
- Simultaneous kill on the output stage with out_ready_i high: no transfer happens, and the upstream item moves in.
- Reset mid-operation discards all items. Acceptance resumes in the first cycle after rst_i falls.
- flush_i has a single-cycle effect. The pipe is empty at the next edge, and acceptance resumes once flush_i is low.

## Test plan
- WIDTH=32, DEPTH=3, reset, then in_valid_i pulsed once with 0xDEADBEEF and out_ready_i=1 -> out_valid_o high exactly 3 cycles later with out_data_o=0xDEADBEEF, then count_o returns to 0.
- Stream 0..9 back-to-back with out_ready_i=1 -> output is 0..9 in order, one per cycle, and in_ready_o never drops.
- out_ready_i=0 while 4 items are offered -> the first 3 are accepted, count_o=3, in_ready_o=0 and the 4th is held. Releasing out_ready_i drains them in order with no loss or duplication.
- Pipe holding A,B,C at stages 2,1,0 with out_ready_i=0, then kill_i=3'b010 for one cycle -> B is dropped, C advances to stage 1, and the output sequence is A, C.
- Full pipe with flush_i asserted together with in_valid_i and out_ready_i -> no transfer either side, and at the next edge stage_valid_o=0 and out_data_o=RESET_DATA.
- rst_i asserted mid-stream while two items are in flight -> the outputs take their reset values at the next edge. The first item offered after reset emerges 3 cycles later and the old items never appear.
